// File: rtl/stall_scoreboard.sv
// Decode-stage stall and mult/div scoreboard: load-use and multdiv hazard detection with one in-flight multdiv.
// Optional sticky stall watchdog is enabled by defining STALL_WATCHDOG_EN.
module stall_scoreboard #(
  parameter int REG_W    = 5,
  parameter int NUM_REGS = 2**REG_W,
  parameter int WD_LIMIT = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                d_valid_i,
  input  logic [REG_W-1:0]    d_rs_i,
  input  logic [REG_W-1:0]    d_rt_i,
  input  logic                d_rs_used_i,
  input  logic                d_rt_used_i,
  input  logic [REG_W-1:0]    d_wr_i,
  input  logic                d_wr_used_i,
  input  logic                d_is_md_i,
  input  logic                x_valid_i,
  input  logic                x_is_load_i,
  input  logic [REG_W-1:0]    x_rd_i,
  input  logic                md_done_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                md_issue_o,
  output logic                md_busy_o,
  output logic [REG_W-1:0]    md_rd_o,
`ifdef STALL_WATCHDOG_EN
  output logic                wd_err_o,
`endif
  output logic [NUM_REGS-1:0] busy_vec_o
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  md_state_e           state_q, state_d;
  logic [REG_W-1:0]    md_rd_q, md_rd_d;
  logic [NUM_REGS-1:0] busy_vec_q, busy_vec_d;

  logic load_hz, md_pend, md_raw, md_waw, md_hz, stall, md_issue;

  assign load_hz = x_valid_i & x_is_load_i & (x_rd_i != '0) &
                   ((d_rs_used_i & (d_rs_i == x_rd_i)) | (d_rt_used_i & (d_rt_i == x_rd_i)));

  // A multdiv finishing this cycle is bypassable, so it no longer blocks decode.
  assign md_pend = (state_q == MD_BUSY) & ~md_done_i;
  assign md_raw  = (md_rd_q != '0) &
                   ((d_rs_used_i & (d_rs_i == md_rd_q)) | (d_rt_used_i & (d_rt_i == md_rd_q)));
  assign md_waw  = (md_rd_q != '0) & d_wr_used_i & (d_wr_i == md_rd_q);
  assign md_hz   = md_pend & (md_raw | md_waw | d_is_md_i);

  assign stall    = d_valid_i & ~flush_i & (load_hz | md_hz);
  assign md_issue = d_valid_i & d_is_md_i & ~stall & ~flush_i;

  always_comb begin
    state_d    = state_q;
    md_rd_d    = md_rd_q;
    busy_vec_d = busy_vec_q;
    if (flush_i) begin
      state_d    = MD_IDLE;
      md_rd_d    = '0;
      busy_vec_d = '0;
    end else begin
      if (state_q == MD_BUSY && md_done_i) begin
        state_d = MD_IDLE;
        if (32'(md_rd_q) < NUM_REGS) busy_vec_d[md_rd_q] = 1'b0;
      end
      // Applied after the retire so a back-to-back issue to the same register keeps its bit.
      if (md_issue) begin
        state_d = MD_BUSY;
        md_rd_d = d_wr_i;
        if (d_wr_used_i && d_wr_i != '0 && 32'(d_wr_i) < NUM_REGS) busy_vec_d[d_wr_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= MD_IDLE;
      md_rd_q    <= '0;
      busy_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      md_rd_q    <= md_rd_d;
      busy_vec_q <= busy_vec_d;
    end
  end

`ifdef STALL_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;

  // Flush already forces stall low, so it clears the count through the same path.
  always_comb begin
    wd_cnt_d = '0;
    if (stall) begin
      wd_cnt_d = wd_cnt_q;
      if (wd_cnt_q != WD_W'(WD_LIMIT)) wd_cnt_d = wd_cnt_q + 1'b1;
    end
    wd_err_d = wd_err_q | (wd_cnt_d == WD_W'(WD_LIMIT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err_o = wd_err_q;
`endif

  assign stall_o    = stall;
  assign md_issue_o = md_issue;
  assign md_busy_o  = (state_q == MD_BUSY);
  assign md_rd_o    = md_rd_q;
  assign busy_vec_o = busy_vec_q;

endmodule

// File: tb/tb_stall_scoreboard.sv
// Bench for stall_scoreboard: directed scenarios plus random traffic against a rule-level model.
module tb_stall_scoreboard;
  localparam int REG_W = 5;
  localparam int NREG  = 32;
  localparam int WDL   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic dv, rsu, rtu, wu, ismd, xv, xl, mdd, fl;
  logic [REG_W-1:0] rs, rt, wr, xrd;
  logic stall, issue, busy;
  logic [REG_W-1:0] md_rd;
  logic [NREG-1:0]  bvec;
  logic wd_err;

  always #5 clk = ~clk;

  stall_scoreboard #(.REG_W(REG_W), .NUM_REGS(NREG), .WD_LIMIT(WDL)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .d_valid_i(dv), .d_rs_i(rs), .d_rt_i(rt), .d_rs_used_i(rsu), .d_rt_used_i(rtu),
    .d_wr_i(wr), .d_wr_used_i(wu), .d_is_md_i(ismd),
    .x_valid_i(xv), .x_is_load_i(xl), .x_rd_i(xrd),
    .md_done_i(mdd), .flush_i(fl),
    .stall_o(stall), .md_issue_o(issue), .md_busy_o(busy), .md_rd_o(md_rd),
`ifdef STALL_WATCHDOG_EN
    .wd_err_o(wd_err),
`endif
    .busy_vec_o(bvec)
  );
`ifndef STALL_WATCHDOG_EN
  assign wd_err = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;

  // Model: at most one multdiv in flight, tracked by its destination and a busy set.
  bit          m_busy, n_busy;
  int          m_rd, n_rd;
  logic [31:0] m_bv, n_bv;
  int          m_cnt, n_cnt;
  bit          m_err, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_in();
    dv = 0; rsu = 0; rtu = 0; wu = 0; ismd = 0; xv = 0; xl = 0; mdd = 0; fl = 0;
    rs = '0; rt = '0; wr = '0; xrd = '0;
  endtask

  task automatic eval();
    int irs, irt, iwr, ixrd;
    bit ld, mh, e_stall, e_issue;
    #2;
    irs = int'(rs); irt = int'(rt); iwr = int'(wr); ixrd = int'(xrd);
    ld = xv && xl && ixrd != 0 && ((rsu && irs == ixrd) || (rtu && irt == ixrd));
    mh = m_busy && !mdd &&
         ((m_rd != 0 && ((rsu && irs == m_rd) || (rtu && irt == m_rd) || (wu && iwr == m_rd))) || ismd);
    e_stall = dv && !fl && (ld || mh);
    e_issue = dv && ismd && !e_stall && !fl;
    chk("stall", 64'(stall), 64'(e_stall));
    chk("md_issue", 64'(issue), 64'(e_issue));
    chk("md_busy", 64'(busy), 64'(m_busy));
    chk("md_rd", 64'(md_rd), 64'(m_rd));
    chk("busy_vec", 64'(bvec), 64'(m_bv));
`ifdef STALL_WATCHDOG_EN
    chk("wd_err", 64'(wd_err), 64'(m_err));
`endif
    n_busy = m_busy; n_rd = m_rd; n_bv = m_bv;
    if (fl) begin
      n_busy = 0; n_rd = 0; n_bv = '0;
    end else begin
      if (m_busy && mdd) begin
        n_busy = 0;
        n_bv[m_rd] = 1'b0;
      end
      if (e_issue) begin
        n_busy = 1;
        n_rd = iwr;
        if (wu && iwr != 0) n_bv[iwr] = 1'b1;
      end
    end
    n_cnt = e_stall ? ((m_cnt < WDL) ? m_cnt + 1 : WDL) : 0;
    n_err = m_err || (n_cnt == WDL);
    if (!rst_n) begin
      n_busy = 0; n_rd = 0; n_bv = '0; n_cnt = 0; n_err = 0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    m_busy = n_busy; m_rd = n_rd; m_bv = n_bv; m_cnt = n_cnt; m_err = n_err;
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 0;
    #1;
    m_busy = 0; m_rd = 0; m_bv = '0; m_cnt = 0; m_err = 0;
    chk("rst_md_busy", 64'(busy), 64'd0);
    chk("rst_busy_vec", 64'(bvec), 64'd0);
    chk("rst_md_rd", 64'(md_rd), 64'd0);
    chk("rst_wd_err", 64'(wd_err), 64'd0);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    clear_in();
    m_busy = 0; m_rd = 0; m_bv = '0; m_cnt = 0; m_err = 0;
    @(posedge clk);
    #1;
    // Combinational stall follows its equation even while reset is held.
    dv = 1; rs = 5'd5; rsu = 1; xv = 1; xl = 1; xrd = 5'd5;
    eval(); chk("reset_comb_stall", 64'(stall), 64'd1);
    adv();
    clear_in(); rst_n = 1;
    eval(); adv();

    // Load-use: lw r5 then add r6,r5,r2.
    dv = 1; rs = 5'd5; rt = 5'd2; rsu = 1; rtu = 1; wr = 5'd6; wu = 1;
    xv = 1; xl = 1; xrd = 5'd5;
    eval(); chk("lu_stall", 64'(stall), 64'd1); adv();
    xv = 0;
    eval(); chk("lu_release", 64'(stall), 64'd0); adv();

    // Load to r0 never hazards.
    xv = 1; xl = 1; xrd = 5'd0; rs = 5'd0; rt = 5'd0;
    eval(); chk("r0_load", 64'(stall), 64'd0); adv();
    clear_in();

    // mul r3 then add r4,r3,r1 stalls until md_done.
    dv = 1; ismd = 1; wr = 5'd3; wu = 1; rs = 5'd1; rt = 5'd2; rsu = 1; rtu = 1;
    eval(); chk("mul_issue", 64'(issue), 64'd1); adv();
    ismd = 0; wr = 5'd4; rs = 5'd3; rt = 5'd1;
    eval(); chk("raw_stall0", 64'(stall), 64'd1); chk("bv3_set", 64'(bvec[3]), 64'd1); adv();
    eval(); chk("raw_stall1", 64'(stall), 64'd1); adv();
    mdd = 1;
    eval(); chk("raw_done_nostall", 64'(stall), 64'd0); adv();
    clear_in();
    eval(); chk("bv3_clear", 64'(bvec[3]), 64'd0); chk("idle_after_done", 64'(busy), 64'd0); adv();

    // Back-to-back div r7 while a div r7 completes.
    dv = 1; ismd = 1; wr = 5'd7; wu = 1;
    eval(); adv();
    mdd = 1;
    eval(); chk("b2b_issue", 64'(issue), 64'd1); adv();
    clear_in();
    eval();
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_rd", 64'(md_rd), 64'd7);
    chk("b2b_bv7", 64'(bvec[7]), 64'd1);
    adv();

    // Flush while busy with a RAW on r7.
    dv = 1; rs = 5'd7; rsu = 1; fl = 1;
    eval(); chk("flush_stall", 64'(stall), 64'd0); chk("flush_issue", 64'(issue), 64'd0); adv();
    clear_in();
    eval(); chk("flush_busy", 64'(busy), 64'd0); chk("flush_bv", 64'(bvec), 64'd0); adv();
    mdd = 1;
    eval(); adv();
    clear_in();
    eval(); chk("idle_done_ignored", 64'(busy), 64'd0); chk("idle_done_bv", 64'(bvec), 64'd0); adv();

`ifdef STALL_WATCHDOG_EN
    dv = 1; ismd = 1; wr = 5'd3; wu = 1;
    eval(); adv();
    ismd = 0; wr = 5'd4; rs = 5'd3; rsu = 1;
    for (int i = 0; i < WDL; i++) begin
      eval(); chk("wd_hold_stall", 64'(stall), 64'd1); adv();
    end
    eval(); chk("wd_set", 64'(wd_err), 64'd1); adv();
    clear_in();
    eval(); adv();
    eval(); chk("wd_sticky", 64'(wd_err), 64'd1); adv();
`endif

    // Reset mid-flight abandons the multdiv.
    clear_in();
    dv = 1; ismd = 1; wr = 5'd9; wu = 1;
    eval(); adv();
    clear_in();
    mid_reset();

    for (int c = 0; c < 1500; c++) begin
      dv   = ($urandom_range(0, 99) < 80);
      rs   = REG_W'($urandom_range(0, 7));
      rt   = REG_W'($urandom_range(0, 7));
      wr   = REG_W'($urandom_range(0, 7));
      rsu  = $urandom_range(0, 1) != 0;
      rtu  = $urandom_range(0, 1) != 0;
      wu   = ($urandom_range(0, 99) < 75);
      ismd = ($urandom_range(0, 99) < 30);
      xv   = $urandom_range(0, 1) != 0;
      xl   = $urandom_range(0, 1) != 0;
      xrd  = REG_W'($urandom_range(0, 7));
      mdd  = ($urandom_range(0, 99) < (m_busy ? 30 : 15));
      fl   = ($urandom_range(0, 99) < 5);
      eval(); adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
